mmio_bus_responder: RTL

//  Responder on the CPU data-memory bus (mem_addr/mem_we/mem_din/mem_dout, read_type/write_type) for the MMIO window.

---
 rtl/mem_bus_pkg.sv | 67 ++++++
 rtl/mmio_tx_fifo.sv | 42 ++++
 rtl/mmio_bus_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared data-memory bus encodings (load/store widths), MMIO register offsets,
// STATUS bit positions and the lane steering helpers used by MEM and MMIO.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    RT_LB  = 3'b000,
    RT_LH  = 3'b001,
    RT_LW  = 3'b010,
    RT_LBU = 3'b100,
    RT_LHU = 3'b101
  } read_type_e;

  typedef enum logic [1:0] {
    WT_SB   = 2'b00,
    WT_SH   = 2'b01,
    WT_SW   = 2'b10,
    WT_RSVD = 2'b11
  } write_type_e;

  localparam logic [2:0] OFF_TX     = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_RX     = 3'd2;
  localparam logic [2:0] OFF_CYC_LO = 3'd3;
  localparam logic [2:0] OFF_CYC_HI = 3'd4;
  localparam logic [2:0] OFF_LED    = 3'd5;
  localparam logic [2:0] OFF_SW     = 3'd6;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_OVR   = 4;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } wr_lanes_t;

  // Right-aligned store data replicated across lanes; be picks the live lanes.
  function automatic wr_lanes_t write_lanes(logic [1:0] wt, logic [1:0] lane, logic [31:0] din);
    wr_lanes_t r;
    r.be   = 4'b0000;
    r.data = din;
    case (wt)
      WT_SB: begin r.be = 4'b0001 << lane;                 r.data = {4{din[7:0]}};  end
      WT_SH: begin r.be = lane[1] ? 4'b1100 : 4'b0011;     r.data = {2{din[15:0]}}; end
      WT_SW: begin r.be = 4'b1111;                         r.data = din;            end
      default: r.be = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(logic [31:0] w, logic [2:0] rt, logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (rt)
      RT_LB:   return {{24{b[7]}}, b};
      RT_LH:   return {{16{h[15]}}, h};
      RT_LBU:  return {24'b0, b};
      RT_LHU:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Console TX FIFO: registered head (no fall-through), extra pointer bit
// distinguishes full from empty; a push while full is taken if a pop frees a slot.
module mmio_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop, do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_bus_responder.sv
// MMIO window responder on the CPU data bus: console TX FIFO, RX holding reg,
// 64-bit cycle counter with consistent HI snapshot, LEDs and synchronised switches.
module mmio_bus_responder
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          TX_DEPTH  = 8,
  parameter int          LED_W     = 16,
  parameter int          SW_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dm_addr,
  input  logic             dm_re,
  input  logic             dm_we,
  input  logic [31:0]      dm_din,
  input  logic [2:0]       read_type,
  input  logic [1:0]       write_type,
  output logic [31:0]      dm_dout,
  output logic             mmio_hit,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_byte,
  input  logic             rx_strobe,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led
);
  logic [2:0]       off;
  wr_lanes_t        wl;
  logic [31:0]      be_mask, led_merged, rd_word;
  logic             wr_en, rd_en;
  logic             tx_full, tx_empty, tx_push, tx_pop, tx_drop, st_w1c;
  logic [63:0]      cycle_cnt;
  logic [31:0]      cyc_snap;
  logic [7:0]       rx_data;
  logic             rx_valid, tx_overflow, rx_overrun;
  logic [SW_W-1:0]  sw_meta, sw_sync;

  assign mmio_hit = (dm_addr[31:5] == BASE_ADDR[31:5]);
  assign off      = dm_addr[4:2];
  assign wl       = write_lanes(write_type, dm_addr[1:0], dm_din);
  assign be_mask  = {{8{wl.be[3]}}, {8{wl.be[2]}}, {8{wl.be[1]}}, {8{wl.be[0]}}};

  // A store in the same cycle as a load wins and suppresses read side effects.
  assign wr_en = dm_we & mmio_hit & (write_type != WT_RSVD);
  assign rd_en = dm_re & mmio_hit & ~dm_we;

  assign tx_push  = wr_en & (off == OFF_TX) & wl.be[0];
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_drop  = tx_push & tx_full & ~tx_pop;
  assign st_w1c   = wr_en & (off == OFF_STATUS) & wl.be[0];
  assign tx_valid = ~tx_empty;

  mmio_tx_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (wl.data[7:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Lanes beyond LED_W fall off in the truncation on write-back.
  assign led_merged = (32'(led) & ~be_mask) | (wl.data & be_mask);

  always_comb begin
    rd_word = '0;
    case (off)
      OFF_STATUS: rd_word = {27'b0, rx_overrun, tx_overflow, tx_full, tx_empty, rx_valid};
      OFF_RX:     rd_word = {24'b0, rx_data};
      OFF_CYC_LO: rd_word = cycle_cnt[31:0];
      OFF_CYC_HI: rd_word = cyc_snap;
      OFF_LED:    rd_word = 32'(led);
      OFF_SW:     rd_word = 32'(sw_sync);
      default:    rd_word = '0;
    endcase
  end

  assign dm_dout = mmio_hit ? load_extend(rd_word, read_type, dm_addr[1:0]) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      cyc_snap    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
      led         <= '0;
      sw_meta     <= '0;
      sw_sync     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      // HI is captured alongside the LO value returned this cycle.
      if (rd_en && off == OFF_CYC_LO) cyc_snap <= cycle_cnt[63:32];
      if (rx_strobe) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rd_en && off == OFF_RX) begin
        rx_valid <= 1'b0;
      end
      // New events beat a simultaneous write-1-to-clear.
      tx_overflow <= tx_drop | (tx_overflow & ~(st_w1c & wl.data[ST_TX_OVF]));
      rx_overrun  <= (rx_strobe & rx_valid) | (rx_overrun & ~(st_w1c & wl.data[ST_RX_OVR]));
      if (wr_en && off == OFF_LED) led <= led_merged[LED_W-1:0];
    end
  end

endmodule
